// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_ctrl_pkg;

  // Controller states; FILL is only reachable when IMEM_NOP_FILL_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    RUN  = 2'd3
  } ctrl_state_e;

  // RISC-V canonical NOP (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Byte PC bit where the imem word address starts (32-bit words).
  localparam int unsigned PC_WORD_LSB = 2;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Bundle of loader, imem and CPU-side signals around imem_load_ctrl.
// master: the controller; slave: loader/imem/CPU environment.
interface imem_load_ctrl_if #(
  parameter int unsigned AW = 8
) ();

  // Loader side
  logic          load_start;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  // imem side
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  // CPU side
  logic [31:0]   cpu_pc;
  logic [31:0]   cpu_instr;
  logic          cpu_stall;
  logic          cpu_rst_pc;
  // Status
  logic          busy;
  logic          overflow;
  logic [AW:0]   word_count;

  modport master (
    input  load_start, ld_valid, ld_data, ld_last, mem_rdata, cpu_pc,
    output ld_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
           cpu_instr, cpu_stall, cpu_rst_pc, busy, overflow, word_count
  );

  modport slave (
    output load_start, ld_valid, ld_data, ld_last, mem_rdata, cpu_pc,
    input  ld_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
           cpu_instr, cpu_stall, cpu_rst_pc, busy, overflow, word_count
  );

endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: stalls the CPU while a loader streams
// program words into consecutive imem addresses, then releases the CPU to
// fetch from address 0.
// Optional macro IMEM_NOP_FILL_EN: pad the rest of imem with NOPs after the
// last loaded word (FILL state) before entering RUN.
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned AW            = 8,
  parameter bit          BOOT_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_load_ctrl_if.master bus
);

  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_W = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE    = (AW+1)'(1);

  ctrl_state_e state_q, state_d;
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        rst_pc_q, rst_pc_d;

  // Only the word-address slice of the PC is used for fetch.
  logic unused_pc;
  assign unused_pc = ^{bus.cpu_pc[31:AW+PC_WORD_LSB], bus.cpu_pc[PC_WORD_LSB-1:0]};

  assign bus.mem_waddr  = wptr_q[AW-1:0];
  assign bus.word_count = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.cpu_rst_pc = rst_pc_q;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rst_pc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rst_pc_q <= rst_pc_d;
    end
  end

  // Next-state, write-port and CPU-path decode.
  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    rst_pc_d      = 1'b0;
    bus.ld_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = bus.ld_data;
    bus.mem_raddr = '0;
    bus.cpu_instr = NOP_INSTR;
    bus.cpu_stall = 1'b1;
    bus.busy      = 1'b1;

    case (state_q)
      IDLE: begin
        wptr_d = '0;
        cnt_d  = '0;
        if (BOOT_ON_RESET) begin
          state_d = LOAD;
        end else begin
          state_d  = RUN;
          rst_pc_d = 1'b1;
        end
      end

      LOAD: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_valid) begin
          // Words past the end are accepted but dropped; wptr and the count
          // stay pinned at DEPTH, so word_count saturates with them.
          if (wptr_q != FULL) begin
            bus.mem_we = 1'b1;
            wptr_d     = wptr_q + ONE;
            cnt_d      = cnt_q + ONE;
          end else begin
            ovf_d = 1'b1;
          end
          if (bus.ld_last) begin
`ifdef IMEM_NOP_FILL_EN
            if (wptr_d != FULL) begin
              state_d = FILL;
            end else begin
              state_d  = RUN;
              rst_pc_d = 1'b1;
            end
`else
            state_d  = RUN;
            rst_pc_d = 1'b1;
`endif
          end
        end
      end

`ifdef IMEM_NOP_FILL_EN
      FILL: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = NOP_INSTR;
        wptr_d        = wptr_q + ONE;
        if (wptr_q == LAST_W) begin
          state_d  = RUN;
          rst_pc_d = 1'b1;
        end
      end
`endif

      RUN: begin
        bus.cpu_stall = 1'b0;
        bus.busy      = 1'b0;
        bus.mem_raddr = bus.cpu_pc[AW+PC_WORD_LSB-1:PC_WORD_LSB];
        bus.cpu_instr = bus.mem_rdata;
        if (bus.load_start) begin
          state_d = LOAD;
          wptr_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized self-checking bench for imem_load_ctrl with a behavioural imem
// beside the DUT and an array-based reference of the expected memory image.
module tb_imem_load_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n;

  imem_load_ctrl_if #(.AW(AW)) bus ();

  imem_load_ctrl #(
    .DEPTH(DEPTH),
    .AW(AW),
    .BOOT_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int a);
    return 32'hC0DE0000 ^ (a * 32'h00010101);
  endfunction

  // imem beside the controller: synchronous write, combinational read.
  logic [31:0] imem [DEPTH];
  logic        seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) imem[i] <= seed_word(i);
      seeded <= 1'b1;
    end else if (bus.mem_we === 1'b1) begin
      imem[bus.mem_waddr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = imem[bus.mem_raddr];

  // Reference model
  logic [31:0] ref_mem [DEPTH];
  int          ref_wptr;
  int          ref_cnt;
  bit          ref_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] prog [9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_stalled(input string tag);
    chk({tag, ".busy"},  32'(bus.busy), 1);
    chk({tag, ".stall"}, 32'(bus.cpu_stall), 1);
    chk({tag, ".instr"}, bus.cpu_instr, NOP);
    chk({tag, ".raddr"}, 32'(bus.mem_raddr), 0);
  endtask

  // Stream n words; ld_valid dropped gap_pct percent of cycles; load_start
  // toggled at random to confirm it is ignored while loading.
  task automatic stream_words(input int n, input int gap_pct, input bit with_last, input bit use_prog);
    int  i = 0;
    int  guard = 0;
    bit  exp_we;
    while (i < n && guard < 4*n + 50) begin
      guard++;
      @(negedge clk);
      bus.ld_valid   = ($urandom_range(99) >= gap_pct);
      bus.ld_data    = use_prog ? prog[i] : $urandom;
      bus.ld_last    = with_last && (i == n - 1);
      bus.load_start = ($urandom_range(7) == 0);
      #1;
      chk("load.ready", 32'(bus.ld_ready), 1);
      chk_stalled("load");
      chk("load.count", 32'(bus.word_count), 32'(ref_cnt));
      chk("load.ovf",   32'(bus.overflow), 32'(ref_ovf));
      exp_we = bus.ld_valid && (ref_wptr < DEPTH);
      chk("load.we", 32'(bus.mem_we), 32'(exp_we));
      if (exp_we) begin
        chk("load.waddr", 32'(bus.mem_waddr), 32'(ref_wptr));
        chk("load.wdata", bus.mem_wdata, bus.ld_data);
      end
      if (bus.ld_valid) begin
        if (ref_wptr < DEPTH) begin
          ref_mem[ref_wptr] = bus.ld_data;
          ref_wptr++;
          ref_cnt++;
        end else begin
          ref_ovf = 1'b1;
        end
        i++;
      end
    end
    chk("stream.done", 32'(i), 32'(n));
  endtask

  task automatic idle_inputs();
    bus.ld_valid   = $urandom_range(1);
    bus.ld_data    = $urandom;
    bus.ld_last    = $urandom_range(1);
    bus.load_start = 1'b0;
  endtask

  task automatic expect_run_entry();
`ifdef IMEM_NOP_FILL_EN
    for (int k = ref_wptr; k < DEPTH; k++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      chk("fill.we",    32'(bus.mem_we), 1);
      chk("fill.waddr", 32'(bus.mem_waddr), 32'(k));
      chk("fill.wdata", bus.mem_wdata, NOP);
      chk("fill.ready", 32'(bus.ld_ready), 0);
      chk("fill.busy",  32'(bus.busy), 1);
      chk("fill.count", 32'(bus.word_count), 32'(ref_cnt));
      ref_mem[k] = NOP;
    end
`endif
    @(negedge clk);
    idle_inputs();
    #1;
    chk("entry.rst_pc", 32'(bus.cpu_rst_pc), 1);
    chk("entry.stall",  32'(bus.cpu_stall), 0);
    chk("entry.busy",   32'(bus.busy), 0);
    chk("entry.ready",  32'(bus.ld_ready), 0);
    chk("entry.we",     32'(bus.mem_we), 0);
    chk("entry.count",  32'(bus.word_count), 32'(ref_cnt));
    chk("entry.ovf",    32'(bus.overflow), 32'(ref_ovf));
    @(negedge clk);
    idle_inputs();
    #1;
    chk("run.rst_pc", 32'(bus.cpu_rst_pc), 0);
    chk("run.stall",  32'(bus.cpu_stall), 0);
  endtask

  task automatic fetch_check(input int a);
    @(negedge clk);
    idle_inputs();
    bus.cpu_pc = {$urandom_range(255) & 32'h3FFFFF, 2'b00, 8'h00} | (a << 2) | $urandom_range(3);
    bus.cpu_pc[31:AW+2] = 22'($urandom);
    #1;
    chk("fetch.raddr", 32'(bus.mem_raddr), 32'(a));
    chk("fetch.instr", bus.cpu_instr, ref_mem[a]);
    chk("fetch.stall", 32'(bus.cpu_stall), 0);
  endtask

  task automatic start_reload();
    @(negedge clk);
    idle_inputs();
    bus.ld_valid   = 1'b0;
    bus.load_start = 1'b1;
    #1;
    chk("reload.busy_before", 32'(bus.busy), 0);
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.ld_valid   = 1'b0;
    #1;
    chk("reload.busy",  32'(bus.busy), 1);
    chk("reload.ready", 32'(bus.ld_ready), 1);
    chk("reload.ovf",   32'(bus.overflow), 0);
    chk("reload.count", 32'(bus.word_count), 0);
    chk("reload.stall", 32'(bus.cpu_stall), 1);
    ref_wptr = 0;
    ref_cnt  = 0;
    ref_ovf  = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ready"},  32'(bus.ld_ready), 0);
    chk({tag, ".we"},     32'(bus.mem_we), 0);
    chk({tag, ".count"},  32'(bus.word_count), 0);
    chk({tag, ".ovf"},    32'(bus.overflow), 0);
    chk({tag, ".rst_pc"}, 32'(bus.cpu_rst_pc), 0);
    chk_stalled(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 32'h00000093; prog[1] = 32'h00A00113; prog[2] = 32'h00B00193;
    prog[3] = 32'h00C00213; prog[4] = 32'h002081B3; prog[5] = 32'h40110233;
    prog[6] = 32'h00418233; prog[7] = 32'h00100313; prog[8] = 32'h00500293;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
    ref_wptr = 0; ref_cnt = 0; ref_ovf = 1'b0;

    rst_n          = 1'b0;
    bus.load_start = 1'b0;
    bus.ld_valid   = 1'b1;
    bus.ld_data    = 32'hDEADBEEF;
    bus.ld_last    = 1'b0;
    bus.cpu_pc     = 32'h00000020;

    // Reset values, with ld_valid held high to show nothing is written.
    repeat (2) @(negedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle.ready", 32'(bus.ld_ready), 0);
    chk("idle.busy",  32'(bus.busy), 1);

    // Boot load of the fixed 9-word program.
    stream_words(9, 0, 1'b1, 1'b1);
    expect_run_entry();
    fetch_check(8);
    chk("boot.pc20", bus.cpu_instr, 32'h00500293);
    for (int k = 0; k < 12; k++) fetch_check($urandom_range(DEPTH - 1));

    // Reload with loader gaps.
    start_reload();
    stream_words(12, 50, 1'b1, 1'b0);
    expect_run_entry();
    for (int k = 0; k < 12; k++) fetch_check(k);
    for (int k = 0; k < 8; k++)  fetch_check($urandom_range(DEPTH - 1));

    // Overflow: DEPTH+3 words.
    start_reload();
    stream_words(DEPTH + 3, 10, 1'b1, 1'b0);
    chk("ovf.model_sat", 32'(ref_cnt), DEPTH);
    expect_run_entry();
    for (int k = 0; k < 16; k++) fetch_check($urandom_range(DEPTH - 1));
    fetch_check(DEPTH - 1);

    // Short reload clears overflow and replaces addresses 0..1.
    start_reload();
    stream_words(2, 30, 1'b1, 1'b0);
    expect_run_entry();
    fetch_check(0);
    fetch_check(1);
    fetch_check(2);

    // Reset in the middle of a load, then a full reload.
    start_reload();
    stream_words(4, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = $urandom;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    #1;
    chk_reset_state("midrst2");
    rst_n = 1'b1;
    #1;
    chk("midrst.idle_ready", 32'(bus.ld_ready), 0);
    chk("midrst.idle_we",    32'(bus.mem_we), 0);
    ref_wptr = 0; ref_cnt = 0; ref_ovf = 1'b0;
    stream_words(9, 25, 1'b1, 1'b0);
    expect_run_entry();
    for (int k = 0; k < DEPTH; k++) fetch_check(k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
